// File: rtl/if_pkg.sv
// ---------------------------------------------------------------------------
// if_pkg : shared definitions for the instruction-fetch stage.
//   - NOP_INSTR       : encoding used for bubbles in pipeline registers
//   - fetch_state_e   : fetch FSM encoding (START / RUN / HALT)
//   - ifid_t          : IF/ID pipeline register payload
//   - reset constants : values loaded while rst_n is low
// ---------------------------------------------------------------------------
package if_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_START = 2'd0,
        ST_RUN   = 2'd1,
        ST_HALT  = 2'd2
    } fetch_state_e;

    // valid sits at the top so the packed value reads {valid, pc+4, instr}.
    typedef struct packed {
        logic        valid;
        logic [31:0] pc_plus4;
        logic [31:0] instr;
    } ifid_t;

    localparam int unsigned IFID_W = $bits(ifid_t);

    // A bubble is a NOP with no PC and valid low; it is also the reset value.
    localparam ifid_t IFID_BUBBLE = '{valid: 1'b0, pc_plus4: 32'h0, instr: NOP_INSTR};

    localparam fetch_state_e RST_STATE  = ST_START;
    localparam logic         RST_HALTED = 1'b0;

endpackage

// File: rtl/ifid_reg.sv
// ---------------------------------------------------------------------------
// ifid_reg : generic pipeline register with load / hold / bubble control.
//   Used for IF/ID; written width-generic so the later ID/EX-style registers
//   can reuse it with their own payload and bubble value.
//
// Ports
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset (loads BUBBLE)
//   load_i    in   capture d_i on the next edge
//   bubble_i  in   load BUBBLE on the next edge (wins over load_i)
//   d_i       in   W-bit payload
//   q_o       out  W-bit registered payload
//   With neither load_i nor bubble_i the register holds.
// ---------------------------------------------------------------------------
module ifid_reg #(
    parameter int unsigned     W      = 65,
    parameter logic [W-1:0]    BUBBLE = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic         bubble_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= BUBBLE;
        end else if (bubble_i) begin
            data_q <= BUBBLE;
        end else if (load_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/if_fetch_stage.sv
// ---------------------------------------------------------------------------
// if_fetch_stage : MIPS instruction-fetch stage.
//   Owns the PC, drives it as a byte address into a combinational big-endian
//   instruction memory and captures the returned word into IF/ID. Handles
//   hazard stall, branch/jump redirect and running off the end of memory.
//
// Ports
//   clk            in   rising-edge clock
//   rst_n          in   asynchronous active-low reset
//   stall          in   hold PC and IF/ID
//   redirect       in   taken branch/jump from a later stage (beats stall)
//   redirect_pc    in   redirect target; low two bits are dropped
//   imem_addr      out  byte address to instruction memory (= PC)
//   imem_data      in   instruction word for imem_addr
//   ifid_instr     out  registered instruction (NOP on bubble)
//   ifid_pc_plus4  out  registered PC+4 of ifid_instr
//   ifid_valid     out  ifid_instr is a real fetched word
//   halted         out  FSM is in HALT
//   fetch_count    out  saturating count of valid words captured
// ---------------------------------------------------------------------------
import if_pkg::*;

module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned MEM_SIZE = 1024,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             redirect,
    input  logic [31:0]      redirect_pc,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_data,
    output logic [31:0]      ifid_instr,
    output logic [31:0]      ifid_pc_plus4,
    output logic             ifid_valid,
    output logic             halted,
    output logic [CNT_W-1:0] fetch_count
);

    // Highest byte address at which a full word can still be fetched.
    localparam logic [31:0] LAST_PC = 32'(MEM_SIZE - 4);

    fetch_state_e     state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic             halted_q;
    logic [CNT_W-1:0] cnt_q;

    logic [31:0]      pc_plus4;
    logic [31:0]      tgt;
    logic             tgt_ok;
    logic             ld_en;
    logic             bub_en;
    logic             cnt_inc;
    ifid_t            ifid_d, ifid_q;

    assign pc_plus4 = pc_q + 32'd4;
    // Masking keeps every redirect_pc bit in the expression; bits [1:0] are
    // simply forced to zero.
    assign tgt      = redirect_pc & ~32'd3;
    assign tgt_ok   = (tgt <= LAST_PC);

    // -----------------------------------------------------------------------
    // Next-state / control decode. Priority: redirect > stall > advance.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ld_en   = 1'b0;
        bub_en  = 1'b0;
        cnt_inc = 1'b0;

        unique case (state_q)
            ST_START, ST_RUN: begin
                if (redirect) begin
                    // Current fetch is wrong-path: squash it.
                    pc_d    = tgt;
                    bub_en  = 1'b1;
                    state_d = tgt_ok ? ST_RUN : ST_HALT;
                end else if (stall) begin
                    // START lasts one cycle even when stalled; an illegal
                    // reset PC goes straight to HALT.
                    if (state_q == ST_START) begin
                        state_d = (pc_q > LAST_PC) ? ST_HALT : ST_RUN;
                    end
                end else if (pc_q > LAST_PC) begin
                    // Only reachable from START with an out-of-range
                    // RESET_PC; memory must not be read here.
                    bub_en  = 1'b1;
                    state_d = ST_HALT;
                end else begin
                    ld_en   = 1'b1;
                    cnt_inc = 1'b1;
                    if (pc_plus4 > LAST_PC) begin
                        // Last legal slot: capture it, then park the PC on it.
                        state_d = ST_HALT;
                    end else begin
                        pc_d    = pc_plus4;
                        state_d = ST_RUN;
                    end
                end
            end

            ST_HALT: begin
                if (redirect) begin
                    bub_en = 1'b1;
                    if (tgt_ok) begin
                        pc_d    = tgt;
                        state_d = ST_RUN;
                    end
                end else if (!stall) begin
                    bub_en = 1'b1;
                end
            end

            default: begin
                state_d = ST_HALT;
                bub_en  = 1'b1;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM, PC and counter state with registered outputs.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= RST_STATE;
            pc_q     <= RESET_PC;
            halted_q <= RST_HALTED;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            halted_q <= (state_d == ST_HALT);
            if (cnt_inc && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // IF/ID register
    // -----------------------------------------------------------------------
    always_comb begin
        ifid_d          = IFID_BUBBLE;
        ifid_d.valid    = 1'b1;
        ifid_d.pc_plus4 = pc_plus4;
        ifid_d.instr    = imem_data;
    end

    ifid_reg #(
        .W      (IFID_W),
        .BUBBLE (IFID_BUBBLE)
    ) u_ifid_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (ld_en),
        .bubble_i (bub_en),
        .d_i      (ifid_d),
        .q_o      (ifid_q)
    );

    assign imem_addr     = pc_q;
    assign ifid_instr    = ifid_q.instr;
    assign ifid_pc_plus4 = ifid_q.pc_plus4;
    assign ifid_valid    = ifid_q.valid;
    assign halted        = halted_q;
    assign fetch_count   = cnt_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_stage : directed + randomized bench for if_fetch_stage.
//   A byte-array memory feeds imem_data; a behavioural model tracks PC,
//   halt status, IF/ID contents and fetch count from the fetch rules.
// ---------------------------------------------------------------------------
module tb_if_fetch_stage;

    localparam int unsigned MEM_SIZE = 1024;
    localparam int unsigned CNT_W    = 4;
    localparam logic [31:0] LAST     = 32'(MEM_SIZE - 4);
    localparam int          CNT_MAX  = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst_n;
    logic             stall;
    logic             redirect;
    logic [31:0]      redirect_pc;
    logic [31:0]      imem_addr;
    logic [31:0]      imem_data;
    logic [31:0]      ifid_instr;
    logic [31:0]      ifid_pc_plus4;
    logic             ifid_valid;
    logic             halted;
    logic [CNT_W-1:0] fetch_count;

    if_fetch_stage #(
        .RESET_PC (32'h0),
        .MEM_SIZE (MEM_SIZE),
        .CNT_W    (CNT_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .ifid_instr    (ifid_instr),
        .ifid_pc_plus4 (ifid_pc_plus4),
        .ifid_valid    (ifid_valid),
        .halted        (halted),
        .fetch_count   (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Big-endian byte memory; out-of-range reads return a marker word.
    logic [7:0] mem [0:MEM_SIZE-1];
    logic [9:0] ia;
    assign ia = imem_addr[9:0];
    always_comb begin
        if (imem_addr > LAST) imem_data = 32'hDEAD_BEEF;
        else imem_data = {mem[ia], mem[ia + 10'd1], mem[ia + 10'd2], mem[ia + 10'd3]};
    end

    function automatic logic [31:0] mword(input logic [31:0] a);
        int i;
        i = int'(a);
        return {mem[i], mem[i+1], mem[i+2], mem[i+3]};
    endfunction

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_pc, m_instr, m_pp4;
    bit          m_valid, m_halt, m_first;
    int          m_cnt;

    task automatic model_reset();
        m_pc = 32'h0; m_instr = 32'h0; m_pp4 = 32'h0;
        m_valid = 0; m_halt = 0; m_first = 1; m_cnt = 0;
    endtask

    task automatic bubble();
        m_instr = 32'h0; m_pp4 = 32'h0; m_valid = 0;
    endtask

    // One clock edge worth of fetch behaviour.
    task automatic model_edge(input bit st, input bit rd, input logic [31:0] rpc);
        logic [31:0] tgt;
        tgt = {rpc[31:2], 2'b00};
        if (rd) begin
            bubble();
            if (tgt <= LAST) begin
                m_pc = tgt; m_halt = 0;
            end else if (!m_halt) begin
                m_pc = tgt; m_halt = 1;
            end
        end else if (st) begin
            if (m_first && m_pc > LAST) m_halt = 1;
        end else if (m_halt || m_pc > LAST) begin
            bubble();
            m_halt = 1;
        end else begin
            m_instr = mword(m_pc);
            m_pp4   = m_pc + 32'd4;
            m_valid = 1;
            if (m_cnt < CNT_MAX) m_cnt++;
            if (m_pc + 32'd4 > LAST) m_halt = 1;
            else m_pc = m_pc + 32'd4;
        end
        m_first = 0;
    endtask

    task automatic cmp_all(input string tag);
        chk({tag, "_addr"},  imem_addr, m_pc);
        chk({tag, "_instr"}, ifid_instr, m_instr);
        chk({tag, "_pp4"},   ifid_pc_plus4, m_pp4);
        chk({tag, "_valid"}, 32'(ifid_valid), 32'(m_valid));
        chk({tag, "_halt"},  32'(halted), 32'(m_halt));
        chk({tag, "_cnt"},   32'(fetch_count), 32'(m_cnt));
    endtask

    // Inputs are applied at the falling edge, outputs checked at the next one.
    task automatic step(input bit st, input bit rd, input logic [31:0] rpc, input string tag);
        stall = st; redirect = rd; redirect_pc = rpc;
        @(posedge clk);
        model_edge(st, rd, rpc);
        @(negedge clk);
        cmp_all(tag);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] cnt_snap;
        int          n;
        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        for (int i = 0; i < MEM_SIZE; i++) mem[i] = 8'($urandom);
        mem[0] = 8'h8C; mem[1] = 8'h01; mem[2] = 8'h00; mem[3] = 8'h00;
        mem[4] = 8'h20; mem[5] = 8'h42; mem[6] = 8'h00; mem[7] = 8'h01;
        model_reset();

        // Reset held for three cycles
        repeat (3) @(negedge clk);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", 32'(ifid_valid), 32'h0);
        cmp_all("rst");
        rst_n = 1'b1;

        // First fetches
        step(0, 0, 0, "f1");
        chk("f1_instr_d", ifid_instr, 32'h8C01_0000);
        chk("f1_pp4_d", ifid_pc_plus4, 32'h4);
        chk("f1_cnt_d", 32'(fetch_count), 32'h1);
        step(0, 0, 0, "f2");
        chk("f2_instr_d", ifid_instr, 32'h2042_0001);
        chk("f2_pp4_d", ifid_pc_plus4, 32'h8);

        // Stall at PC=8
        step(1, 0, 0, "st1");
        step(1, 0, 0, "st2");
        chk("st_addr_d", imem_addr, 32'h8);
        chk("st_instr_d", ifid_instr, 32'h2042_0001);
        chk("st_cnt_d", 32'(fetch_count), 32'h2);
        step(0, 0, 0, "st_rel");
        chk("st_rel_pp4_d", ifid_pc_plus4, 32'hC);
        chk("st_rel_instr_d", ifid_instr, mword(32'h8));

        // Redirect with stall and misaligned target at PC=0x10
        step(0, 0, 0, "to10");
        chk("to10_addr_d", imem_addr, 32'h10);
        step(1, 1, 32'h43, "rd");
        chk("rd_addr_d", imem_addr, 32'h40);
        chk("rd_instr_d", ifid_instr, 32'h0);
        chk("rd_valid_d", 32'(ifid_valid), 32'h0);
        step(0, 0, 0, "rd_cap");
        chk("rd_cap_instr_d", ifid_instr, mword(32'h40));
        chk("rd_cap_pp4_d", ifid_pc_plus4, 32'h44);

        // Run to the end of memory
        n = 0;
        while (!halted && n < 400) begin
            step(0, 0, 0, "seq");
            n++;
        end
        chk("end_halt", 32'(halted), 32'h1);
        chk("end_valid", 32'(ifid_valid), 32'h1);
        chk("end_instr", ifid_instr, mword(32'h3FC));
        chk("end_pp4", ifid_pc_plus4, 32'h400);
        chk("end_addr", imem_addr, 32'h3FC);
        cnt_snap = 32'(fetch_count);
        repeat (3) step(0, 0, 0, "halt");
        chk("halt_valid", 32'(ifid_valid), 32'h0);
        chk("halt_cnt", 32'(fetch_count), cnt_snap);
        chk("halt_addr", imem_addr, 32'h3FC);
        step(0, 1, 32'h400, "rd_oob");
        chk("rd_oob_halt", 32'(halted), 32'h1);
        step(0, 1, 32'h0, "rd_back");
        chk("rd_back_halt", 32'(halted), 32'h0);
        chk("rd_back_addr", imem_addr, 32'h0);
        step(0, 0, 0, "resume");
        chk("resume_instr", ifid_instr, 32'h8C01_0000);
        chk("resume_pp4", ifid_pc_plus4, 32'h4);

        // Async reset mid-cycle at PC=0x20
        repeat (7) step(0, 0, 0, "to20");
        chk("to20_addr", imem_addr, 32'h20);
        chk("to20_valid", 32'(ifid_valid), 32'h1);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("arst_addr", imem_addr, 32'h0);
        chk("arst_valid", 32'(ifid_valid), 32'h0);
        chk("arst_cnt", 32'(fetch_count), 32'h0);
        chk("arst_halt", 32'(halted), 32'h0);
        @(negedge clk);
        cmp_all("arst_hold");
        rst_n = 1'b1;

        // Counter saturation
        repeat (20) step(0, 0, 0, "sat");
        chk("sat_cnt", 32'(fetch_count), 32'hF);
        step(0, 0, 0, "sat2");
        chk("sat2_cnt", 32'(fetch_count), 32'hF);

        // Random stall / redirect traffic, targets biased toward the end
        for (int k = 0; k < 600; k++) begin
            bit          st, rd;
            logic [31:0] rpc;
            st  = ($urandom_range(0, 3) == 0);
            rd  = ($urandom_range(0, 9) == 0);
            rpc = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(32'h3E0, 32'h40F))
                                              : 32'($urandom_range(0, 32'h47F));
            step(st, rd, rpc, "rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
